encode: RTL

Transmit-side framer for the UART-to-SDRAM loopback path. When the SDRAM read path signals that a burst of read bytes has been written into the read FIFO, this block sends a header byte followed by exactly BYTE_NUM bytes popped from that FIFO. It hands them one at a time to the uart_tx byte transmitter, using a trigger/busy handshake. It is the return direction of the command decoder that turns received UART bytes into SDRAM write/read triggers.

---
 rtl/encode_if.sv | 25 ++
 rtl/encode.sv | 100 ++++++++++
 2 files changed

// File: rtl/encode_if.sv
// Handshake bundle between the frame encoder, the read FIFO and the uart_tx byte transmitter.
// Latency: none; wires only.
// Backpressure: tx_busy stalls byte issue, rfifo_empty stalls pops.
interface encode_if;
   logic       rd_done;
   logic       rfifo_empty;
   logic [7:0] rfifo_rd_data;
   logic       rfifo_rd_en;
   logic       tx_busy;
   logic       tx_trig;
   logic [7:0] tx_data;
   logic       tx_done;

   // encoder side
   modport slave (
      input  rd_done, rfifo_empty, rfifo_rd_data, tx_busy,
      output rfifo_rd_en, tx_trig, tx_data, tx_done
   );

   // environment side (read path, FIFO, uart_tx)
   modport master (
      output rd_done, rfifo_empty, rfifo_rd_data, tx_busy,
      input  rfifo_rd_en, tx_trig, tx_data, tx_done
   );
endinterface

// File: rtl/encode.sv
// Transmit framer: on rd_done sends HEAD then BYTE_NUM bytes popped from the read FIFO to uart_tx.
// Latency: rd_done -> header tx_trig 1 cycle; busy low -> pop 1 cycle; pop -> tx_trig 2 cycles.
// Backpressure: waits on tx_busy per byte; holds in POP while the FIFO is empty; one start may queue.
module encode #(
   parameter int         BYTE_NUM = 4,
   parameter logic [7:0] HEAD     = 8'hAA
) (
   input  logic      clk,
   input  logic      rst_n,
   encode_if.slave   bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT_H = 3'd1;
   localparam logic [2:0] S_WAIT_L = 3'd2;
   localparam logic [2:0] S_POP    = 3'd3;
   localparam logic [2:0] S_LOAD   = 3'd4;

   localparam logic [7:0] LAST_CNT = 8'(BYTE_NUM);

   logic [2:0] r_state;
   logic [7:0] r_cnt;
   logic       r_pend;
   logic       r_tx_trig;
   logic [7:0] r_tx_data;
   logic       r_tx_done;

   logic       w_start;
   logic       w_pop;

   assign w_start = bus.rd_done | r_pend;
   // Normal-mode FIFO: pop only in POP and never on an empty FIFO.
   assign w_pop   = (r_state == S_POP) & ~bus.rfifo_empty;

   assign bus.rfifo_rd_en = w_pop;
   assign bus.tx_trig     = r_tx_trig;
   assign bus.tx_data     = r_tx_data;
   assign bus.tx_done     = r_tx_done;

   // Start latch: remembers one rd_done seen while a frame is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= 1'b0;
      end else if (r_state != S_IDLE) begin
         if (bus.rd_done) r_pend <= 1'b1;
      end else if (w_start) begin
         r_pend <= 1'b0;
      end
   end

   // Frame sequencer: header, then per byte wait busy high/low, pop, load and trigger.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= 8'd0;
         r_tx_trig <= 1'b0;
         r_tx_data <= 8'h00;
         r_tx_done <= 1'b0;
      end else begin
         r_tx_trig <= 1'b0;
         r_tx_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_tx_data <= HEAD;
                  r_tx_trig <= 1'b1;
                  r_cnt     <= 8'd0;
                  r_state   <= S_WAIT_H;
               end
            end
            S_WAIT_H: begin
               if (bus.tx_busy) r_state <= S_WAIT_L;
            end
            S_WAIT_L: begin
               if (!bus.tx_busy) begin
                  if (r_cnt == LAST_CNT) begin
                     r_state   <= S_IDLE;
                     r_tx_done <= 1'b1;
                  end else begin
                     r_state <= S_POP;
                  end
               end
            end
            S_POP: begin
               if (!bus.rfifo_empty) r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_tx_data <= bus.rfifo_rd_data;
               r_tx_trig <= 1'b1;
               r_cnt     <= r_cnt + 8'd1;
               r_state   <= S_WAIT_H;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
